// File: rtl/mem_sweep_reader_if.sv
// Bus bundle for mem_sweep_reader: sweep control, memory read port and output stream.
interface mem_sweep_reader_if #(
    parameter int WID_MEM = 1
);
    logic               start;
    logic [6:0]         first_addr;
    logic [6:0]         last_addr;
    logic [6:0]         raddr;
    logic [WID_MEM-1:0] mem_dout;
    logic               m_valid;
    logic               m_ready;
    logic [WID_MEM-1:0] m_data;
    logic [6:0]         m_addr;
    logic               m_last;
    logic               busy;
    logic               done;

    modport master (
        input  start, first_addr, last_addr, mem_dout, m_ready,
        output raddr, m_valid, m_data, m_addr, m_last, busy, done
    );

    modport slave (
        output start, first_addr, last_addr, mem_dout, m_ready,
        input  raddr, m_valid, m_data, m_addr, m_last, busy, done
    );
endinterface

// File: rtl/mem_sweep_reader.sv
// Sweeps a synchronous-read memory from first_addr to last_addr (with wrap) and
// streams {data, addr, last} through a 2-entry FIFO with valid/ready backpressure.
module mem_sweep_reader #(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 128
) (
    input logic               clk,
    input logic               reset,
    mem_sweep_reader_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [6:0]         raddr_q, raddr_d;
    logic [6:0]         last_q, last_d;
    logic               pend_q, pend_d;
    logic [6:0]         pend_addr_q, pend_addr_d;
    logic               pend_last_q, pend_last_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [WID_MEM-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [6:0]         addr0_q, addr0_d, addr1_q, addr1_d;
    logic               last0_q, last0_d, last1_q, last1_d;
    logic               done_q, done_d;

    logic       pop;
    logic       issue_en;
    logic       at_last;
    logic [2:0] occ_after;
    logic [1:0] wr_idx;

    assign pop     = (cnt_q != 2'd0) && bus.m_ready;
    assign at_last = (raddr_q == last_q);
    // Slots that will be committed after this cycle: FIFO entries plus the word in flight.
    assign occ_after = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start)          state_d = S_RUN;
            S_RUN:   if (issue_en && at_last) state_d = S_DRAIN;
            S_DRAIN: if (pop && last0_q)      state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue_en = (state_q == S_RUN) && (occ_after < 3'd2);
        done_d   = (state_q == S_DRAIN) && pop && last0_q;
    end

    always_comb begin
        raddr_d     = raddr_q;
        last_d      = last_q;
        if (state_q == S_IDLE && bus.start) begin
            raddr_d = bus.first_addr;
            last_d  = bus.last_addr;
        end else if (issue_en && !at_last) begin
            raddr_d = (raddr_q == 7'(DEPTH_MEM - 1)) ? 7'd0 : raddr_q + 7'd1;
        end
        pend_d      = issue_en;
        pend_addr_d = raddr_q;
        pend_last_d = at_last;
    end

    always_comb begin
        data0_d = data0_q; addr0_d = addr0_q; last0_d = last0_q;
        data1_d = data1_q; addr1_d = addr1_q; last1_d = last1_q;
        if (pop) begin
            data0_d = data1_q; addr0_d = addr1_q; last0_d = last1_q;
        end
        // The returned word lands behind whatever survives this cycle's pop.
        wr_idx = cnt_q - {1'b0, pop};
        if (pend_q) begin
            if (wr_idx == 2'd0) begin
                data0_d = bus.mem_dout; addr0_d = pend_addr_q; last0_d = pend_last_q;
            end else begin
                data1_d = bus.mem_dout; addr1_d = pend_addr_q; last1_d = pend_last_q;
            end
        end
        cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raddr_q     <= '0;
            last_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_last_q <= 1'b0;
            cnt_q       <= '0;
            data0_q     <= '0;
            addr0_q     <= '0;
            last0_q     <= 1'b0;
            data1_q     <= '0;
            addr1_q     <= '0;
            last1_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            raddr_q     <= raddr_d;
            last_q      <= last_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_last_q <= pend_last_d;
            cnt_q       <= cnt_d;
            data0_q     <= data0_d;
            addr0_q     <= addr0_d;
            last0_q     <= last0_d;
            data1_q     <= data1_d;
            addr1_q     <= addr1_d;
            last1_q     <= last1_d;
            done_q      <= done_d;
        end
    end

    assign bus.raddr   = raddr_q;
    assign bus.m_valid = (cnt_q != 2'd0);
    assign bus.m_data  = data0_q;
    assign bus.m_addr  = addr0_q;
    assign bus.m_last  = last0_q && (cnt_q != 2'd0);
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;

endmodule

// File: tb/tb_mem_sweep_reader.sv
// Randomized bench for mem_sweep_reader: a queue of expected beats per sweep is
// built from the address arithmetic and every output beat is checked against it.
module tb_mem_sweep_reader;
  localparam int W = 8;
  localparam int D = 128;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_sweep_reader_if #(.WID_MEM(W)) bus();
  mem_sweep_reader #(.WID_MEM(W), .DEPTH_MEM(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [W-1:0] ram [D];
  always @(posedge clk) bus.mem_dout <= ram[bus.raddr];

  typedef struct { int addr; logic last; } beat_t;
  beat_t exp_q[$];
  int got_addr[$];
  int checks = 0;
  int errors = 0;
  int beats_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every live cycle against the expected-beat queue.
  logic done_exp = 1'b0;
  logic stall_prev = 1'b0;
  logic [W-1:0] pd;
  logic [6:0] pa;
  logic pl;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      done_exp = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("done_pulse", bus.done, done_exp);
      if (bus.done) chk("busy_low_at_done", bus.busy, 0);
      done_exp = 1'b0;
      if (stall_prev && bus.m_valid) begin
        chk("stall_data_stable", bus.m_data, pd);
        chk("stall_addr_stable", bus.m_addr, pa);
        chk("stall_last_stable", bus.m_last, pl);
      end
      if (bus.m_valid) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk("m_addr", bus.m_addr, exp_q[0].addr);
          chk("m_data", bus.m_data, ram[exp_q[0].addr]);
          chk("m_last", bus.m_last, exp_q[0].last);
          chk("busy_during_beat", bus.busy, 1);
          if (bus.m_ready) begin
            done_exp = exp_q[0].last;
            got_addr.push_back(int'(bus.m_addr));
            void'(exp_q.pop_front());
            beats_acc++;
          end
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      pd = bus.m_data; pa = bus.m_addr; pl = bus.m_last;
    end
  end

  function automatic int beat_count(input int f, input int l);
    return (((l - f) % D) + D) % D + 1;
  endfunction

  // Runs one sweep from IDLE; mode 0 = m_ready high, 1 = random 50% ready.
  task automatic sweep(input int f, input int l, input int mode, input bit stray);
    int n, cyc, done_cyc;
    bit seen_valid, got_done;
    n = beat_count(f, l);
    for (int k = 0; k < n; k++) exp_q.push_back('{(f + k) % D, k == n - 1});
    bus.m_ready = (mode == 1) ? 1'($urandom % 2) : 1'b1;
    bus.first_addr = 7'(f);
    bus.last_addr = 7'(l);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.first_addr = 7'($urandom);
    bus.last_addr = 7'($urandom);
    cyc = 0; done_cyc = 0; seen_valid = 0; got_done = 0;
    while (!got_done && cyc < 800) begin
      @(negedge clk); cyc++;
      if (bus.m_valid && !seen_valid) begin
        seen_valid = 1;
        if (mode == 0) chk("first_valid_latency", cyc, 3);
      end
      if (bus.done) begin got_done = 1; done_cyc = cyc; end
      @(posedge clk); #1;
      if (mode == 1) bus.m_ready = 1'($urandom % 2);
      if (stray && cyc == 2) begin
        bus.start = 1'b1;
        bus.first_addr = 7'(f + 50);
        bus.last_addr = 7'(f + 52);
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("sweep_done_seen", got_done, 1);
    if (mode == 0) chk("done_cycle", done_cyc, n + 3);
    chk("no_beats_left", exp_q.size(), 0);
    chk("raddr_hold_idle", bus.raddr, l);
    chk("busy_idle", bus.busy, 0);
  endtask

  int wrap_exp[4] = '{126, 127, 0, 1};

  initial begin
    for (int i = 0; i < D; i++) ram[i] = {7'($urandom), 1'(i)};
    bus.start = 1'b0;
    bus.first_addr = '0;
    bus.last_addr = '0;
    bus.m_ready = 1'b1;
    #2;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_raddr", bus.raddr, 0);
    chk("rst_m_data", bus.m_data, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    chk("model_count_wrap", beat_count(126, 1), 4);
    chk("model_count_full", beat_count(0, 127), 128);
    chk("model_count_single", beat_count(5, 5), 1);

    got_addr.delete();
    sweep(0, 127, 0, 0);
    chk("full_beats", got_addr.size(), 128);
    if (got_addr.size() == 128) chk("full_last_addr", got_addr[127], 127);

    got_addr.delete();
    sweep(126, 1, 0, 0);
    chk("wrap_beats", got_addr.size(), 4);
    for (int i = 0; i < 4 && i < got_addr.size(); i++) chk("wrap_addr", got_addr[i], wrap_exp[i]);

    got_addr.delete();
    sweep(40, 55, 1, 0);
    chk("bp_beats", got_addr.size(), 16);

    got_addr.delete();
    sweep(5, 5, 0, 0);
    chk("single_beats", got_addr.size(), 1);
    if (got_addr.size() == 1) chk("single_addr", got_addr[0], 5);

    got_addr.delete();
    sweep(10, 40, 0, 1);
    chk("stray_start_beats", got_addr.size(), 31);

    for (int r = 0; r < 6; r++) begin
      int f, l;
      f = int'($urandom % D);
      l = (f + int'($urandom % 21)) % D;
      sweep(f, l, int'($urandom % 2), 0);
    end

    // Abandon a long sweep with the output stalled, then confirm a clean restart.
    begin
      int b0, guard;
      b0 = beats_acc;
      for (int k = 0; k < D; k++) exp_q.push_back('{k, k == D - 1});
      bus.m_ready = 1'b1;
      bus.first_addr = 7'd0;
      bus.last_addr = 7'd127;
      bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      guard = 0;
      while (beats_acc < b0 + 10 && guard < 50) begin @(negedge clk); guard++; end
      chk("rst_mid_reached_10", 32'(beats_acc >= b0 + 10), 1);
      @(posedge clk); #1 bus.m_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_m_valid", bus.m_valid, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_raddr", bus.raddr, 0);
      chk("mid_rst_m_addr", bus.m_addr, 0);
      chk("mid_rst_m_last", bus.m_last, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      bus.m_ready = 1'b1;
      repeat (5) begin
        @(negedge clk);
        chk("post_rst_idle_valid", bus.m_valid, 0);
        chk("post_rst_idle_busy", bus.busy, 0);
      end
      @(posedge clk); #1;
      got_addr.delete();
      sweep(0, 3, 0, 0);
      chk("post_rst_beats", got_addr.size(), 4);
      if (got_addr.size() == 4) chk("post_rst_first_addr", got_addr[0], 0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_sweep_reader.md
MEM_SWEEP_READER -- requirements
Module: mem_sweep_reader

Interface
REQ-001 Parameter WID_MEM, default 1: width of one memory word and of the output data stream.
REQ-002 Parameter DEPTH_MEM, default 128: number of memory words; addresses are 7 bits, so DEPTH_MEM SHALL be at most 128.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: when high in IDLE, begins a sweep.
REQ-006 first_addr  input  7: first address read; sampled when start is accepted.
REQ-007 last_addr  input  7: final address read; sampled when start is accepted.
REQ-008 raddr  output  7: read address to the memory read port.
REQ-009 mem_dout  input  WID_MEM: memory read data, valid one clock edge after raddr is presented.
REQ-010 m_valid  output  1: output beat is available.
REQ-011 m_ready  input  1: downstream accepts the beat when high together with m_valid.
REQ-012 m_data  output  WID_MEM: data word of the current beat.
REQ-013 m_addr  output  7: address the current beat was read from.
REQ-014 m_last  output  1: current beat is the final beat of the sweep.
REQ-015 busy  output  1: high in RUN and DRAIN.
REQ-016 done  output  1: one-cycle pulse on sweep completion.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN; the reset state SHALL be IDLE.
REQ-018 IDLE->RUN SHALL occur on the edge where start=1; first_addr and last_addr SHALL be captured on that edge, and start SHALL be ignored outside IDLE.
REQ-019 Beat count SHALL be ((last_addr - first_addr) mod DEPTH_MEM) + 1; first_addr == last_addr SHALL give 1 beat.
REQ-020 Addresses SHALL increment by 1 and wrap from DEPTH_MEM-1 to 0 (example: first=126, last=1 reads 126,127,0,1).
REQ-021 A read issue SHALL be a cycle in RUN with raddr = current address and issue enable high; the returned word SHALL be captured from mem_dout on the following edge.
REQ-022 Captured words SHALL go into a 2-entry output FIFO holding {data, addr, last}; m_data/m_addr/m_last SHALL present the head entry, and m_valid SHALL equal FIFO not-empty.
REQ-023 A read SHALL be issued only if FIFO occupancy + reads in flight - (pop this cycle) < 2, so the FIFO never overflows and no word is lost under backpressure.
REQ-024 With m_ready held high, the block SHALL sustain one beat per cycle.
REQ-025 With m_ready held high, the first m_valid SHALL occur 3 cycles after the cycle in which start was sampled.
REQ-026 m_data, m_addr and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-027 RUN->DRAIN SHALL occur on the edge where the final address is issued, and raddr SHALL then hold that address.
REQ-028 DRAIN->IDLE SHALL occur on the edge where the m_last beat is accepted; done SHALL be high for the single following cycle, with busy low in that cycle.
REQ-029 In IDLE, raddr SHALL hold its last value and no read SHALL be issued.

Reset
REQ-030 Asserting reset (low) SHALL immediately force: state=IDLE, m_valid=0, m_last=0, busy=0, done=0, raddr=0, m_addr=0, m_data=0, and the FIFO empty with no reads in flight.
REQ-031 Reset asserted mid-sweep SHALL abandon the sweep; after release, no beats from the abandoned sweep SHALL appear and the block SHALL wait for a new start.

Verification
REQ-032 Full sweep: memory initialised so ram[i]=i[0], first=0, last=127, m_ready=1 -> 128 beats on consecutive cycles, m_addr 0..127, m_last only on addr 127, one done pulse.
REQ-033 Wrap sweep: first=126, last=1 -> exactly 4 beats with m_addr 126,127,0,1; m_last on addr 1.
REQ-034 Backpressure: m_ready random 50% over a 16-beat sweep -> no dropped or duplicated beats, outputs stable while stalled, FIFO never exceeds 2 entries.
REQ-035 Single beat: first=last=5 -> exactly one beat with m_addr=5, m_last=1, and done one cycle after acceptance.
REQ-036 Reset mid-sweep: assert reset after 10 beats with m_ready=0 -> m_valid drops at once; after release and a new start with first=0, last=3, exactly 4 fresh beats appear.
REQ-037 Start while busy: pulse start with different addresses during RUN -> ignored, and the original sweep completes unchanged.
